// File: rtl/exe_unit_w12_pkg.sv
// Shared types and constants for the exe_unit_w12 scheduler slice.
package exe_unit_w12_pkg;

  localparam int STATUS_W = 4;
  localparam int OPER_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef logic [OPER_W-1:0] oper_t;

  localparam oper_t OPER_00 = 2'b00;
  localparam oper_t OPER_01 = 2'b01;
  localparam oper_t OPER_10 = 2'b10;
  localparam oper_t OPER_11 = 2'b11;

  // Requester index to one-hot pair, used for grant/done vectors.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/exe_unit_w12_arbiter_rr_arb2.sv
// Two-way arbiter with registered round-robin pointer.
// Build option: EXE_ARB_FIXED_PRIO_EN turns it into fixed priority (requester 0 wins).
module rr_arb2
  import exe_unit_w12_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

`ifdef EXE_ARB_FIXED_PRIO_EN

  logic unused_ok;
  assign unused_ok = ^{clk, rst, update};

  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

`else

  // High when requester 1 holds priority for the next contested grant.
  logic favour1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      favour1 <= 1'b0;
    end else if (update && (gnt != 2'b00)) begin
      favour1 <= gnt[0];
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = onehot2(favour1);
      default: gnt = 2'b00;
    endcase
  end

`endif

endmodule

// File: rtl/exe_unit_w12_arbiter.sv
// Two-requester scheduler sharing one exe_unit_w12: registered issue, fixed-latency wait, done return.
// Build option: EXE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module exe_unit_w12_arbiter
  import exe_unit_w12_pkg::*;
#(
  parameter int M   = 4,
  parameter int N   = 2,
  parameter int LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rsn,
  input  logic                i_req0,
  input  logic [N-1:0]        i_oper0,
  input  logic [M-1:0]        i_a0,
  input  logic [M-1:0]        i_b0,
  output logic                o_gnt0,
  output logic                o_done0,
  input  logic                i_req1,
  input  logic [N-1:0]        i_oper1,
  input  logic [M-1:0]        i_a1,
  input  logic [M-1:0]        i_b1,
  output logic                o_gnt1,
  output logic                o_done1,
  output logic [N-1:0]        o_oper,
  output logic [M-1:0]        o_argA,
  output logic [M-1:0]        o_argB,
  input  logic [M-1:0]        i_result,
  input  logic [STATUS_W-1:0] i_status,
  output logic [M-1:0]        o_result,
  output logic [STATUS_W-1:0] o_status,
  output logic                o_busy
);

  localparam int CNT_W = 3;

  arb_state_t          state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                owner, owner_nx;
  logic [1:0]          gnt, gnt_nx;
  logic [1:0]          done, done_nx;
  logic                busy_nx;
  logic [N-1:0]        oper_nx;
  logic [M-1:0]        arga_nx, argb_nx, result_nx;
  logic [STATUS_W-1:0] status_nx;
  logic [1:0]          arb_gnt;
  logic                arb_update;

  rr_arb2 u_arb (
    .clk    (i_clk),
    .rst    (i_rsn),
    .req    ({i_req1, i_req0}),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    owner_nx   = owner;
    gnt_nx     = 2'b00;
    done_nx    = 2'b00;
    oper_nx    = o_oper;
    arga_nx    = o_argA;
    argb_nx    = o_argB;
    result_nx  = o_result;
    status_nx  = o_status;
    arb_update = 1'b0;

    unique case (state)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          arb_update = 1'b1;
          owner_nx   = arb_gnt[1];
          gnt_nx     = arb_gnt;
          cnt_nx     = CNT_W'(LAT);
          state_nx   = WAIT;
          if (arb_gnt[1]) begin
            oper_nx = i_oper1;
            arga_nx = i_a1;
            argb_nx = i_b1;
          end else begin
            oper_nx = i_oper0;
            arga_nx = i_a0;
            argb_nx = i_b0;
          end
        end
      end
      // Counter reaching zero marks the edge where the unit's result is valid.
      WAIT: begin
        if (cnt == '0) begin
          result_nx = i_result;
          status_nx = i_status;
          done_nx   = onehot2(owner);
          state_nx  = DONE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= 1'b0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      o_busy   <= 1'b0;
      o_oper   <= '0;
      o_argA   <= '0;
      o_argB   <= '0;
      o_result <= '0;
      o_status <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      owner    <= owner_nx;
      gnt      <= gnt_nx;
      done     <= done_nx;
      o_busy   <= busy_nx;
      o_oper   <= oper_nx;
      o_argA   <= arga_nx;
      o_argB   <= argb_nx;
      o_result <= result_nx;
      o_status <= status_nx;
    end
  end

  assign o_gnt0  = gnt[0];
  assign o_gnt1  = gnt[1];
  assign o_done0 = done[0];
  assign o_done1 = done[1];

endmodule

// File: tb/tb_exe_unit_w12_arbiter.sv
// Randomised and directed bench for exe_unit_w12_arbiter against a timeline-based reference model.
`timescale 1ns/1ps
module tb_exe_unit_w12_arbiter;

  localparam int M   = 4;
  localparam int N   = 2;
  localparam int LAT = 1;
  localparam int VW  = 5 + N + 3 * M + 4;

  logic         clk = 1'b0;
  logic         rsn = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [N-1:0] oper0 = '0, oper1 = '0;
  logic [M-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic         o_gnt0, o_gnt1, o_done0, o_done1, o_busy;
  logic [N-1:0] o_oper;
  logic [M-1:0] o_argA, o_argB, o_result;
  logic [3:0]   o_status;
  logic [M-1:0] ex_result;
  logic [3:0]   ex_status;

  int n_cmp = 0;
  int n_bad = 0;

  exe_unit_w12_arbiter #(.M(M), .N(N), .LAT(LAT)) dut (
    .i_clk(clk), .i_rsn(rsn),
    .i_req0(req0), .i_oper0(oper0), .i_a0(a0), .i_b0(b0), .o_gnt0(o_gnt0), .o_done0(o_done0),
    .i_req1(req1), .i_oper1(oper1), .i_a1(a1), .i_b1(b1), .o_gnt1(o_gnt1), .o_done1(o_done1),
    .o_oper(o_oper), .o_argA(o_argA), .o_argB(o_argB),
    .i_result(ex_result), .i_status(ex_status),
    .o_result(o_result), .o_status(o_status), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Stand-in exe unit: result/status of {oper, A, B}, LAT edges of latency.
  function automatic logic [M+3:0] exe_fn(input logic [N-1:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r, 4'(a ^ b)};
  endfunction

  logic [M+3:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= exe_fn(o_oper, o_argA, o_argB);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {ex_result, ex_status} = pipe[LAT-1];

  // Reference model: edges elapsed since acceptance (-1 when idle) plus last granted requester.
  function automatic bit pick(input bit r0, input bit r1, input bit last);
`ifdef EXE_ARB_FIXED_PRIO_EN
    return r0 ? 1'b0 : 1'b1;
`else
    return (r0 && r1) ? ~last : r1;
`endif
  endfunction

  int           since;
  bit           owner, last_g;
  logic [1:0]   e_gnt, e_done;
  logic [N-1:0] e_oper;
  logic [M-1:0] e_a, e_b, e_res;
  logic [3:0]   e_st;

  always @(posedge clk or posedge rsn) begin
    if (rsn) begin
      since <= -1; last_g <= 1'b1; owner <= 1'b0;
      e_gnt <= '0; e_done <= '0; e_oper <= '0; e_a <= '0; e_b <= '0; e_res <= '0; e_st <= '0;
    end else begin
      e_gnt  <= '0;
      e_done <= '0;
      if (since < 0) begin
        if (req0 || req1) begin
          owner  <= pick(req0, req1, last_g);
          last_g <= pick(req0, req1, last_g);
          since  <= 0;
          e_gnt  <= pick(req0, req1, last_g) ? 2'b10 : 2'b01;
          e_oper <= pick(req0, req1, last_g) ? oper1 : oper0;
          e_a    <= pick(req0, req1, last_g) ? a1 : a0;
          e_b    <= pick(req0, req1, last_g) ? b1 : b0;
        end
      end else if (since <= LAT) begin
        since <= since + 1;
        if (since == LAT) begin
          e_done        <= owner ? 2'b10 : 2'b01;
          {e_res, e_st} <= exe_fn(e_oper, e_a, e_b);
        end
      end else begin
        since <= -1;
      end
    end
  end

  logic [VW-1:0] act_vec, exp_vec;
  assign act_vec = {o_gnt1, o_gnt0, o_done1, o_done0, o_busy, o_oper, o_argA, o_argB, o_result, o_status};
  assign exp_vec = {e_gnt[1], e_gnt[0], e_done[1], e_done[0], (since >= 0), e_oper, e_a, e_b, e_res, e_st};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n_cmp++;
    if (act_vec !== exp_vec) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, act_vec, exp_vec);
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rsn = 1'b1;
    step(); step();
    rsn = 1'b0;
    step();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (o_busy && k < 40) begin step(); k++; end
    check("idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, busy=%0b expected idle", o_busy);
    $fatal(1);
  end

  initial begin
    int        n_g, g_first, g_second, first_who, idle_n;
    logic [M-1:0] r0, r1;
    logic [3:0]   order, exp_order;
    bit        got, got0, got1, p0, p1;

    // Reset state and single request.
    do_reset();
    check("reset_state", 32'(act_vec), 32'd0);
    req0 = 1'b1; oper0 = 2'b00; a0 = 4'd2; b0 = 4'd3;
    step();
    check("t1_gnt0", 32'(o_gnt0), 32'd1);
    check("t1_gnt1", 32'(o_gnt1), 32'd0);
    check("t1_argA", 32'(o_argA), 32'd2);
    req0 = 1'b0;
    repeat (LAT) step();
    check("t1_no_done_yet", 32'(o_done0), 32'd0);
    step();
    check("t1_done0", 32'(o_done0), 32'd1);
    check("t1_result", 32'(o_result), 32'd5);
    check("t1_done1", 32'(o_done1), 32'd0);
    step();
    check("t1_done_clear", 32'(o_done0), 32'd0);
    check("t1_result_hold", 32'(o_result), 32'd5);
    check("t1_busy_low", 32'(o_busy), 32'd0);

    // Simultaneous requests.
    do_reset();
    req0 = 1'b1; oper0 = 2'b00; a0 = 4'd4; b0 = 4'd5;
    req1 = 1'b1; oper1 = 2'b00; a1 = 4'd8; b1 = 4'd8;
    n_g = 0; g_first = -1; g_second = -1; first_who = -1; idle_n = 0;
    r0 = '1; r1 = '1; got0 = 1'b0; got1 = 1'b0;
    for (int c = 0; c < 40 && !(got0 && got1); c++) begin
      step();
      if (o_gnt0 || o_gnt1) begin
        if (n_g == 0) begin first_who = int'(o_gnt1); g_first = c; end
        else g_second = c;
        n_g++;
      end
      if (o_gnt0) req0 = 1'b0;
      if (o_gnt1) req1 = 1'b0;
      if (n_g == 1 && !o_busy) idle_n++;
      if (o_done0) begin r0 = o_result; got0 = 1'b1; end
      if (o_done1) begin r1 = o_result; got1 = 1'b1; end
    end
    check("t2_grants", 32'(n_g), 32'd2);
    check("t2_first_winner", 32'(first_who), 32'd0);
    check("t2_issue_period", 32'(g_second - g_first), 32'(LAT + 3));
    check("t2_result0", 32'(r0), 32'd9);
    check("t2_result1", 32'(r1), 32'd0);
    check("t2_idle_cycles", 32'(idle_n), 32'd1);
    wait_idle();

    // Fairness with both requests held.
    do_reset();
    oper0 = N'($urandom); a0 = M'($urandom); b0 = M'($urandom);
    oper1 = N'($urandom); a1 = M'($urandom); b1 = M'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    order = '0; n_g = 0;
    for (int c = 0; c < 80 && n_g < 4; c++) begin
      step();
      if (o_gnt0 || o_gnt1) begin order[n_g] = o_gnt1; n_g++; end
    end
    req0 = 1'b0; req1 = 1'b0;
`ifdef EXE_ARB_FIXED_PRIO_EN
    exp_order = 4'b0000;
`else
    exp_order = 4'b1010;
`endif
    check("t3_grant_count", 32'(n_g), 32'd4);
    check("t3_grant_order", 32'(order), 32'(exp_order));
    wait_idle();

    // Status passthrough.
    do_reset();
    req0 = 1'b1; oper0 = 2'b00; a0 = 4'b1100; b0 = 4'b0110;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (o_gnt0) req0 = 1'b0;
      if (o_done0) got = 1'b1;
    end
    check("t4_done_seen", 32'(got), 32'd1);
    check("t4_status", 32'(o_status), 32'hA);
    check("t4_result", 32'(o_result), 32'd2);
    step(); step();
    check("t4_status_hold", 32'(o_status), 32'hA);
    check("t4_done_clear", 32'({o_done1, o_done0}), 32'd0);

    // Asynchronous reset during WAIT.
    do_reset();
    req0 = 1'b1; oper0 = 2'b01; a0 = 4'd1; b0 = 4'd1;
    step();
    check("t5_gnt0", 32'(o_gnt0), 32'd1);
    req0 = 1'b0;
    #1 rsn = 1'b1;
    #1 check("t5_async_clear", 32'(act_vec), 32'd0);
    step(); step();
    rsn = 1'b0;
    req1 = 1'b1; oper1 = 2'b00; a1 = 4'd3; b1 = 4'd5;
    step();
    check("t5_gnt1_after_reset", 32'({o_gnt1, o_gnt0}), 32'd2);
    req1 = 1'b0;
    wait_idle();
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("t5_rr_gnt0", 32'({o_gnt1, o_gnt0}), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // Randomised traffic obeying the requester contract.
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 1502) rsn = 1'b0;
      if (p0 && o_gnt0) begin p0 = 1'b0; req0 = 1'b0; end
      if (p1 && o_gnt1) begin p1 = 1'b0; req1 = 1'b0; end
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; req0 = 1'b1;
        oper0 = N'($urandom); a0 = M'($urandom); b0 = M'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; req1 = 1'b1;
        oper1 = N'($urandom); a1 = M'($urandom); b1 = M'($urandom);
      end
      if (c == 1500) begin
        #1 rsn = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
